axi_burst_writer: RTL

AXI4 write-only master that is the responder to the transfer-initiator handshake (init_tx in, tx_done out). Each rising edge of init_tx launches one fixed-length INCR burst. The burst carries samples taken from a valid/ready stream into a circular DDR capture region. tx_done pulses when the write response has been received, so the initiator can trigger the next burst.

---
 rtl/axi_master_pkg.sv | 12 +
 rtl/axi_burst_writer_if.sv | 21 ++
 rtl/axi_addr_gen.sv | 19 +
 rtl/axi_burst_writer.sv | 63 ++++++
 4 files changed

// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared FSM states, AXI encodings and a width helper for the burst writer
package axi_master_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/axi_burst_writer_if.sv
// axi_burst_writer_if: AXI4 write-only channel bundle between the burst writer and its slave
interface axi_burst_writer_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize;
  logic [1:0] m_awburst;
  logic m_awvalid, m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready;
  logic [1:0] m_bresp;
  logic m_bvalid, m_bready;
  modport master(
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input m_awready, m_wready, m_bresp, m_bvalid
  );
  modport slave(
    input m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: circular burst address pointer, advanced by one burst per adv pulse
module axi_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int STEP = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] REGION_BYTES = 32'h0001_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + REGION_BYTES;
  logic [ADDR_W-1:0] nxt;
  assign nxt = addr + ADDR_W'(STEP);
  always_ff @(posedge clk or posedge rst)
    if (rst) addr <= BASE_ADDR;
    else if (adv) addr <= nxt == END_ADDR ? BASE_ADDR : nxt;
endmodule

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: AXI4 write master streaming one fixed INCR burst per init_tx rising edge
module axi_burst_writer
  import axi_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST_LEN = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] REGION_BYTES = 32'h0001_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic init_tx,
  output logic tx_done,
  output logic tx_error,
  input  logic [DATA_W-1:0] s_data,
  input  logic s_valid,
  output logic s_ready,
  axi_burst_writer_if.master m
);
  state_t state, nxt;
  logic init_q, start, last, beat_ok, b_ok;
  logic [7:0] beat;
  logic [ADDR_W-1:0] ptr;
  assign start = init_tx & ~init_q;
  assign last = beat == 8'(BURST_LEN - 1);
  assign beat_ok = state == DATA && s_valid && m.m_wready;
  assign b_ok = state == RESP && m.m_bvalid;
  axi_addr_gen #(
    .ADDR_W(ADDR_W), .STEP(BURST_LEN * DATA_W / 8), .BASE_ADDR(BASE_ADDR), .REGION_BYTES(REGION_BYTES)
  ) u_addr_gen (.clk(clk), .rst(rst), .adv(b_ok), .addr(ptr));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      init_q <= 1'b0;
      beat <= '0;
      tx_error <= 1'b0;
    end else begin
      state <= nxt;
      init_q <= init_tx;
      if (beat_ok) beat <= last ? '0 : beat + 8'd1;
      if (b_ok && m.m_bresp[1]) tx_error <= 1'b1;
    end
  always_comb begin
    nxt = state == IDLE ? (start ? ADDR : IDLE)
        : state == ADDR ? (m.m_awready ? DATA : ADDR)
        : state == DATA ? (beat_ok && last ? RESP : DATA)
        : state == RESP ? (m.m_bvalid ? DONE : RESP)
        : IDLE;
    m.m_awvalid = state == ADDR;
    m.m_wvalid = state == DATA && s_valid;
    s_ready = state == DATA && m.m_wready;
    m.m_bready = state == RESP;
    tx_done = state == DONE;
    m.m_awaddr = ptr;
    m.m_awlen = 8'(BURST_LEN - 1);
    m.m_awsize = 3'(clog2(DATA_W / 8));
    m.m_awburst = BURST_INCR;
    m.m_wdata = s_data;
    m.m_wstrb = '1;
    m.m_wlast = last;
  end
endmodule
